// File: rtl/cycle_step_controller_pkg.sv
// Shared encodings for the run/step sequencer: command opcodes and FSM states.
package cycle_step_controller_pkg;

  localparam logic [1:0] CMD_STOP = 2'd0;
  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_STEP = 2'd2;
  localparam logic [1:0] CMD_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

endpackage

// File: rtl/step_down_counter.sv
// Loadable down-counter: load beats clear beats decrement; zero flag for the caller.
module step_down_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             clear_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (clear_i) begin
      count_d = '0;
    end else if (dec_i) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/cycle_step_controller.sv
// Run/step sequencer producing a registered clock_enable that free-runs, runs N cycles,
// or stops on command or external halt.
module cycle_step_controller
  import cycle_step_controller_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic                   halt_request,
  output logic                   clock_enable,
  output logic                   running,
  output logic                   done,
  output logic                   halted,
  output logic                   cmd_error,
  output logic [COUNT_WIDTH-1:0] steps_left,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  state_e state_q, state_d;
  logic clock_enable_q, clock_enable_d;
  logic done_q, done_d;
  logic halted_q, halted_d;
  logic cmd_error_q, cmd_error_d;
  logic [COUNT_WIDTH-1:0] cycle_count_q;

  logic cmd_stop, cmd_run, cmd_step, cmd_rsvd;
  logic end_op, end_halt;
  logic cnt_load, cnt_clear, cnt_dec, steps_zero;

  assign cmd_ready = 1'b1;
  assign cmd_stop  = cmd_valid && (cmd_op == CMD_STOP);
  assign cmd_run   = cmd_valid && (cmd_op == CMD_RUN);
  assign cmd_step  = cmd_valid && (cmd_op == CMD_STEP);
  assign cmd_rsvd  = cmd_valid && (cmd_op == CMD_RSVD);
  assign cnt_dec   = clock_enable_q && !steps_zero;

  step_down_counter #(
    .Width (COUNT_WIDTH)
  ) u_steps (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .load_i       (cnt_load),
    .load_value_i (cmd_count),
    .clear_i      (cnt_clear),
    .dec_i        (cnt_dec),
    .count_o      (steps_left),
    .zero_o       (steps_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      clock_enable_q <= 1'b0;
      done_q         <= 1'b0;
      halted_q       <= 1'b0;
      cmd_error_q    <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      clock_enable_q <= clock_enable_d;
      done_q         <= done_d;
      halted_q       <= halted_d;
      cmd_error_q    <= cmd_error_d;
      cycle_count_q  <= cycle_count_q + COUNT_WIDTH'(clock_enable_q);
    end
  end

  // Halt outranks STOP, which outranks natural STEP completion; only one can end an op.
  always_comb begin
    state_d   = state_q;
    end_op    = 1'b0;
    end_halt  = 1'b0;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Drops the value left behind by a halted STEP one cycle after done.
        cnt_clear = 1'b1;
        if (cmd_run) begin
          state_d = RUN;
        end else if (cmd_step) begin
          if (cmd_count == '0) begin
            end_op = 1'b1;
          end else begin
            state_d  = STEP;
            cnt_load = 1'b1;
          end
        end
      end
      RUN: begin
        if (halt_request) begin
          state_d  = IDLE;
          end_halt = 1'b1;
        end else if (cmd_stop) begin
          state_d = IDLE;
          end_op  = 1'b1;
        end
      end
      STEP: begin
        if (halt_request) begin
          state_d  = IDLE;
          end_halt = 1'b1;
        end else if (cmd_stop) begin
          state_d   = IDLE;
          end_op    = 1'b1;
          cnt_clear = 1'b1;
        end else if (steps_left == COUNT_WIDTH'(1)) begin
          state_d = IDLE;
          end_op  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clock_enable_d = (state_d != IDLE);
    done_d         = end_op || end_halt;
    halted_d       = done_d ? end_halt : halted_q;
    cmd_error_d    = cmd_rsvd || ((state_q != IDLE) && (cmd_run || cmd_step));
  end

  assign clock_enable = clock_enable_q;
  assign running      = (state_q != IDLE);
  assign done         = done_q;
  assign halted       = halted_q;
  assign cmd_error    = cmd_error_q;
  assign cycle_count  = cycle_count_q;

endmodule
